// File: rtl/udc_pkg.sv
// Shared types for the parametrised up/down counter: the priority-decoded
// operation and the bit positions consumers use when packing the event flags.
package udc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } udc_op_e;

  localparam int UDC_FLAG_WRAP = 0;
  localparam int UDC_FLAG_SAT  = 1;
  localparam int UDC_FLAG_W    = 2;

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-count logic for updown_counter_param: applies one decoded
// operation to q and reports whether a step wrapped or was blocked by saturation.
module udc_next_calc
  import udc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic [WIDTH-1:0] q,
  input  udc_op_e          op,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_Q   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q   = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   EXT_MAX = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0]   EXT_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] ext_q;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  // One extra bit lets the up step compare against MAX_VAL and the down step
  // detect a borrow, independent of the natural 2**WIDTH rollover.
  assign ext_q = {1'b0, q};
  assign inc   = ext_q + EXT_ONE;
  assign dec   = ext_q - EXT_ONE;

  always_comb begin
    next_q = q;
    wrap   = 1'b0;
    sat    = 1'b0;
    case (op)
      OP_CLR: next_q = RST_Q;
      OP_LOAD: begin
        if ({1'b0, load_data} > EXT_MAX) next_q = MAX_Q;
        else                              next_q = load_data;
      end
      OP_UP: begin
        if (inc > EXT_MAX) begin
          if (sat_mode) sat = 1'b1;
          else begin
            next_q = '0;
            wrap   = 1'b1;
          end
        end else begin
          next_q = inc[WIDTH-1:0];
        end
      end
      OP_DOWN: begin
        if (dec[WIDTH]) begin
          if (sat_mode) sat = 1'b1;
          else begin
            next_q = MAX_Q;
            wrap   = 1'b1;
          end
        end else begin
          next_q = dec[WIDTH-1:0];
        end
      end
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clear, load, wrap/saturate and event pulses.
// Define UDC_SNAPSHOT_EN to add the snap input and snap_q capture register.
module updown_counter_param
  import udc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
`ifdef UDC_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_q,
`endif
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_evt,
  output logic             sat_evt
);

  localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > 30 || MAX_VAL < 1 || MAX_VAL >= (2**WIDTH) ||
      RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_param_err
    $error("updown_counter_param: illegal WIDTH/MAX_VAL/RST_VAL combination");
  end

  udc_op_e        op;
  logic [WIDTH-1:0] next_q;
  logic           wrap;
  logic           sat;

  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = up ? OP_UP : OP_DOWN;
  end

  udc_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .RST_VAL (RST_VAL)
  ) u_next (
    .q         (q),
    .op        (op),
    .sat_mode  (sat_mode),
    .load_data (load_data),
    .next_q    (next_q),
    .wrap      (wrap),
    .sat       (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RST_Q;
      wrap_evt <= 1'b0;
      sat_evt  <= 1'b0;
    end else begin
      q        <= next_q;
      wrap_evt <= wrap;
      sat_evt  <= sat;
    end
  end

`ifdef UDC_SNAPSHOT_EN
  // Captures the post-update count, so a snap on a clr edge records RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    snap_q <= RST_Q;
    else if (snap) snap_q <= next_q;
  end
`endif

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=4, MAX_VAL=9, RST_VAL=0):
// directed vector table, async reset and snapshot sequences, randomized model check.
module tb_updown_counter_param;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int RSTV = 0;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         load;
  logic [W-1:0] load_data;
  logic         en;
  logic         up;
  logic         sat_mode;
  logic [W-1:0] q;
  logic         at_max;
  logic         at_min;
  logic         wrap_evt;
  logic         sat_evt;
`ifdef UDC_SNAPSHOT_EN
  logic         snap;
  logic [W-1:0] snap_q;
`endif

  int checks;
  int errors;

  int mq;
  int mwrap;
  int msat;

  typedef struct {
    logic c;
    logic l;
    int   ld;
    logic e;
    logic u;
    logic s;
    int   exp_q;
    int   exp_wrap;
    int   exp_sat;
  } vec_t;

  vec_t tbl[27];

  updown_counter_param #(
    .WIDTH   (W),
    .MAX_VAL (MAXV),
    .RST_VAL (RSTV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_data (load_data),
    .en        (en),
    .up        (up),
    .sat_mode  (sat_mode),
`ifdef UDC_SNAPSHOT_EN
    .snap      (snap),
    .snap_q    (snap_q),
`endif
    .q         (q),
    .at_max    (at_max),
    .at_min    (at_min),
    .wrap_evt  (wrap_evt),
    .sat_evt   (sat_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: range 0..MAXV treated as a ring of MAXV+1 values.
  task automatic modelEdge(input logic c, input logic l, input int ld,
                           input logic e, input logic u, input logic s);
    int nxt;
    mwrap = 0;
    msat  = 0;
    if (c) mq = RSTV;
    else if (l) mq = (ld > MAXV) ? MAXV : ld;
    else if (e) begin
      nxt = u ? mq + 1 : mq - 1;
      if (nxt < 0 || nxt > MAXV) begin
        if (s) msat = 1;
        else begin
          mq    = (nxt + MAXV + 1) % (MAXV + 1);
          mwrap = 1;
        end
      end else begin
        mq = nxt;
      end
    end
  endtask

  task automatic applyStimulus(input logic c, input logic l, input int ld,
                               input logic e, input logic u, input logic s);
    clr       = c;
    load      = l;
    load_data = ld[W-1:0];
    en        = e;
    up        = u;
    sat_mode  = s;
    modelEdge(c, l, ld, e, u, s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input int eq, input int ew, input int es);
    checkOutput({tag, ".q"}, int'(q), eq);
    checkOutput({tag, ".wrap_evt"}, int'(wrap_evt), ew);
    checkOutput({tag, ".sat_evt"}, int'(sat_evt), es);
    checkOutput({tag, ".at_max"}, int'(at_max), (eq == MAXV) ? 1 : 0);
    checkOutput({tag, ".at_min"}, int'(at_min), (eq == 0) ? 1 : 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    load      = 1'b0;
    load_data = '0;
    en        = 1'b0;
    up        = 1'b0;
    sat_mode  = 1'b0;
`ifdef UDC_SNAPSHOT_EN
    snap      = 1'b0;
`endif
    mq = RSTV; mwrap = 0; msat = 0;

    //               c     l     ld  e     u     s     q  w  s
    tbl[0]  = '{1'b0, 1'b1,  7, 1'b0, 1'b0, 1'b0,  7, 0, 0};
    tbl[1]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  8, 0, 0};
    tbl[2]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  9, 0, 0};
    tbl[3]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  0, 1, 0};
    tbl[4]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0,  0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0,  9, 1, 0};
    tbl[7]  = '{1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b1,  0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b1,  0, 0, 1};
    tbl[9]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b1,  0, 0, 1};
    tbl[10] = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b1,  0, 0, 1};
    tbl[11] = '{1'b0, 1'b1, 13, 1'b0, 1'b0, 1'b0,  9, 0, 0};
    tbl[12] = '{1'b1, 1'b1,  5, 1'b0, 1'b0, 1'b0,  0, 0, 0};
    tbl[13] = '{1'b0, 1'b1,  4, 1'b1, 1'b1, 1'b0,  4, 0, 0};
    tbl[14] = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0,  3, 0, 0};
    tbl[15] = '{1'b0, 1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 0, 0};
    tbl[16] = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1,  3, 0, 0};
    tbl[17] = '{1'b0, 1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 0, 0};
    tbl[18] = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1,  3, 0, 0};
    tbl[19] = '{1'b0, 1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 0, 0};
    tbl[20] = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  4, 0, 0};
    tbl[21] = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0,  3, 0, 0};
    tbl[22] = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b0,  4, 0, 0};
    tbl[23] = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0,  3, 0, 0};
    tbl[24] = '{1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b1,  9, 0, 0};
    tbl[25] = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 1'b1,  9, 0, 1};
    tbl[26] = '{1'b1, 1'b0,  0, 1'b1, 1'b1, 1'b1,  0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_init", RSTV, 0, 0);
`ifdef UDC_SNAPSHOT_EN
    checkOutput("reset_init.snap_q", int'(snap_q), RSTV);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      applyStimulus(tbl[i].c, tbl[i].l, tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].s);
      checkAll($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_wrap, tbl[i].exp_sat);
    end

    // Asynchronous reset mid-count, taking effect between clock edges.
    applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst.q", int'(q), 6);
    clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", RSTV, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkAll($sformatf("rst_hold%0d", i), RSTV, 0, 0);
    end
    rst_n = 1'b1;
    mq = RSTV; mwrap = 0; msat = 0;
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkAll("post_rst", RSTV, 0, 0);

`ifdef UDC_SNAPSHOT_EN
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("snap_pre.q", int'(q), 4);
    snap = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    snap = 1'b0;
    checkOutput("snap_cap", int'(snap_q), 5);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("snap_hold", int'(snap_q), 5);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("snap_clr", int'(snap_q), 5);
    checkOutput("snap_clr.q", int'(q), RSTV);
`endif

    // Randomized traffic checked against the ring model.
    for (int i = 0; i < 400; i++) begin
      logic c, l, e, u, s;
      int   ld;
      c  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 7) == 0);
      ld = $urandom_range(0, 15);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) != 0;
      s  = $urandom_range(0, 1) != 0;
      applyStimulus(c, l, ld, e, u, s);
      checkAll($sformatf("rand%0d", i), mq, mwrap, msat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter, the next generation of the team's fixed 3-bit up/down counter.
- Adds configurable width and modulus, count enable, parallel load, wrap or saturate mode, and boundary/event flags.
- Used as a general-purpose event/position counter in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- MAX_VAL, 2**WIDTH-1, top of count range; counter spans 0..MAX_VAL. Must satisfy MAX_VAL < 2**WIDTH and MAX_VAL >= 1.
- RST_VAL, 0, value loaded on reset and on clr. Must satisfy RST_VAL <= MAX_VAL.
- Violating any constraint is an elaboration-time error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear to RST_VAL.
- load  in  1  synchronous parallel load strobe.
- load_data  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
- q  out  WIDTH  registered count.
- at_max  out  1  combinational, q == MAX_VAL.
- at_min  out  1  combinational, q == 0.
- wrap_evt  out  1  registered one-cycle pulse: wrap occurred on the last edge.
- sat_evt  out  1  registered one-cycle pulse: saturation blocked a step on the last edge.

Behaviour:
- Reset (rst_n low, asynchronous): q = RST_VAL; wrap_evt = 0; sat_evt = 0. All outputs held while rst_n is low. Assertion mid-count takes effect immediately, without a clock edge.
- Per-edge priority: clr > load > en > hold.
  - clr: q <= RST_VAL.
  - load: q <= load_data if load_data <= MAX_VAL, else q <= MAX_VAL (clamp).
  - en, no clr/load: count step; en=0: q holds.
- Up step:
  - q < MAX_VAL: q+1.
  - q == MAX_VAL, sat_mode=0: q <= 0, wrap_evt <= 1.
  - q == MAX_VAL, sat_mode=1: q holds, sat_evt <= 1.
- Down step:
  - q > 0: q-1.
  - q == 0, sat_mode=0: q <= MAX_VAL, wrap_evt <= 1.
  - q == 0, sat_mode=1: q holds, sat_evt <= 1.
- wrap_evt and sat_evt are 0 on every edge with no boundary step, including clr/load edges, so they are always single-cycle pulses. Consecutive boundary events give consecutive pulses.
- Latency: q updates 1 cycle after the sampled control; flags align with the new q.
- Arithmetic: internal next value computed WIDTH+1 bits wide; the boundary compare uses MAX_VAL, never the natural 2**WIDTH rollover.
- Inputs sampled every edge; up and sat_mode may change every cycle.
- load and clr together: clr wins, load_data ignored.

Optional Feature:
- Macro: UDC_SNAPSHOT_EN.
- Defined: adds input snap (1) and output snap_q (WIDTH).
  - On an edge with snap=1, snap_q <= the value q takes on that edge, i.e. the post-update count.
  - snap_q resets to RST_VAL; unaffected by clr.
- Undefined: ports and register absent; the rest of the behaviour is identical.

Decomposition:
- Package udc_pkg:
  - enum typedef udc_op_e {OP_HOLD, OP_CLR, OP_LOAD, OP_UP, OP_DOWN} for the priority decode.
  - localparam-style constants for the flag bit positions used by consumers.
- Sub-module udc_next_calc: combinational; takes q, op, sat_mode, load_data and returns next_q, wrap, sat. The top holds only registers and the priority decode.

Test Plan (WIDTH=4, MAX_VAL=9, RST_VAL=0 unless noted):
- Reset: rst_n low mid-count at q=6, no clock edge -> q=0 and flags 0 immediately; hold 3 cycles -> unchanged.
- Wrap up: sat_mode=0, up=1, en=1 from q=7, 4 edges -> q=8,9,0,1; wrap_evt high only on the cycle q=0.
- Wrap down and saturate: sat_mode=0, up=0 from q=1, 2 edges -> 0, 9 with wrap_evt on 9. Then sat_mode=1, load 0, down 3 edges -> q stays 0, sat_evt high 3 consecutive cycles, wrap_evt 0.
- Load clamp and priority:
  - load=1, load_data=13 -> q=9, at_max=1.
  - load=1, clr=1, load_data=5 -> q=0.
  - en=1 with load=1, load_data=4 -> q=4, no step.
- Hold and direction change: en=0 for 5 cycles at q=3 -> q=3; then toggle up each cycle with en=1 -> q alternates 4,3,4,3.
- Snapshot (UDC_SNAPSHOT_EN): counting up from 2, snap=1 on the edge q goes 4->5 -> snap_q=5; snap_q holds while counting continues and after clr.
